multi_hit_scan_encoder: RTL and testbench
=========================================

Name: multi_hit_scan_encoder

Overview:
- Sequential, parametrised successor to the fixed-width multi-detect priority encoder.
- Captures a hit vector, such as lease-expired candidates or tag matches from the lease cache, and streams out every set index. Order is ascending, lowest index first, one index per accepted handshake.
- Reports hit count, multi-hit status and empty-vector events.
- Sits between the cache line-status array and the eviction/replacement controller.

Parameters:
- WIDTH, 1024, hit vector width. Any value >= 2; non-power-of-4 widths are internally zero-padded.
- BW, $clog2(WIDTH), index width. Derived; do not override.
- CW, $clog2(WIDTH+1), count width. Derived; do not override.

Ports:
- clk  input  1  sole clock, rising edge
- rst  input  1  reset, synchronous, active-low
- in_valid  input  1  vector offered
- in_ready  output  1  block can accept a vector
- in_vec  input  WIDTH  hit vector, bit i = candidate i
- flush  input  1  abort current scan
- out_valid  output  1  out_idx valid
- out_ready  input  1  consumer takes out_idx
- out_idx  output  BW  current lowest set index
- out_last  output  1  out_idx is final remaining hit
- hit_count  output  CW  popcount of captured vector, held for whole scan
- multi_hit  output  1  captured vector had >= 2 bits set, held for whole scan
- empty_pulse  output  1  one-cycle pulse: accepted vector was all-zero
- busy  output  1  state != IDLE

Behaviour:
- Reset applies when rst == 0 at a rising clk edge; reset has priority over all other inputs.
- Reset state:
  - state = IDLE; internal vector = 0.
  - in_ready = 1.
  - out_valid = 0, out_idx = 0, out_last = 0.
  - hit_count = 0, multi_hit = 0, empty_pulse = 0, busy = 0.
- Reset asserted mid-scan discards all remaining indices, with no further out_valid.
- States: IDLE and SCAN.
- IDLE:
  - in_ready = 1.
  - Handshake happens when in_valid && in_ready at edge N.
  - Capture in_vec and register hit_count = popcount(in_vec) and multi_hit = (popcount >= 2).
  - Nonzero vector: go to SCAN. out_valid = 1 from cycle N+1; first-index latency is 1 cycle.
  - Zero vector: stay in IDLE and drive empty_pulse = 1 during cycle N+1 only. hit_count = 0, multi_hit = 0.
- SCAN:
  - in_ready = 0.
  - out_valid = 1.
  - out_idx = lowest set bit of the internal vector. This is combinational from the registered vector, so no pipeline bubble.
  - out_last = 1 when exactly one bit remains.
  - On out_valid && out_ready with out_last = 0: clear bit out_idx and stay in SCAN. The next index is presented the following cycle, giving 1 index/cycle throughput under continuous out_ready.
  - On out_valid && out_ready with out_last = 1: clear the bit and go to IDLE. out_valid = 0 and in_ready = 1 on the next cycle.
  - With out_ready = 0: out_idx, out_last and out_valid hold stable. No retraction is allowed.
- flush:
  - In SCAN, flush = 1 forces IDLE next cycle, clears the vector, and deasserts out_valid. The flush takes priority over a same-cycle out handshake; that index counts as not consumed.
  - In IDLE, flush = 1 blocks acceptance that cycle (in_ready = 0) and has no other effect.
- hit_count and multi_hit:
  - Updated only on vector capture; they do not decrement during the scan.
  - Cleared on flush and on reset.
- A new vector cannot be accepted in the same cycle as the final handshake. There is one idle cycle between scans.
- Index WIDTH-1 must be reachable. A full all-ones vector yields WIDTH outputs, and hit_count = WIDTH fits in CW bits.
- Padding bits added for non-power-of-4 WIDTH are always 0 and never appear on out_idx.

Decomposition:
- Shared package pe_pkg holds:
  - function clog4 (number of radix-4 levels);
  - function padded width (next power of 4 >= WIDTH);
  - the state enumeration constants ST_IDLE and ST_SCAN.
- One sub-module, pe_lowest_multi_detect:
  - Purely combinational, parametrised WIDTH, radix-4 recursive lowest-index encoder.
  - Outputs: idx, vld, multi (>= 2 bits set) and last (exactly 1 bit set = vld && !multi).
  - Used once on the registered vector, which supplies out_idx and out_last. The top level owns the FSM, the popcount, and the capture and clear registers.

Test Plan:
- WIDTH=16, rst low 2 cycles, then high -> all outputs at reset values, in_ready = 1.
- in_vec = 16'h8421, out_ready = 1 -> out_idx sequence 0, 5, 10, 15 on consecutive cycles. out_last = 1 only with 15. hit_count = 4, multi_hit = 1. in_ready returns to 1 the cycle after the idx 15 handshake.
- in_vec = 16'h0000 -> empty_pulse high exactly one cycle, out_valid never asserts, hit_count = 0, busy stays 0.
- in_vec = 16'h0100, out_ready held low 5 cycles then high -> out_idx = 8 and out_last = 1 stable for 6 cycles. multi_hit = 0, hit_count = 1. Returns to IDLE after the handshake.
- in_vec = 16'hFFFF, assert flush together with out_ready after 3 handshakes (0, 1, 2 consumed) -> next cycle out_valid = 0, hit_count = 0, busy = 0. A following in_vec = 16'h0002 yields out_idx = 1.
- WIDTH=1024 (and WIDTH=10 padded), single bit at WIDTH-1 -> out_idx = 1023 (resp. 9), out_last = 1. rst pulled low mid-scan on 16'hFFFF -> out_valid = 0 the next cycle.

Source files
------------

// File: rtl/pe_pkg.sv
// pe_pkg: shared constants and helpers for the radix-4 multi-hit scan encoder.
package pe_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    function automatic int clog4(input int n);
        int l = 1;
        while ((1 << (2 * l)) < n) l++;
        return l;
    endfunction

    function automatic int pad_width(input int n);
        return 1 << (2 * clog4(n));
    endfunction

    function automatic logic two_plus(input logic [3:0] v);
        return (v[0] & (v[1] | v[2] | v[3])) | (v[1] & (v[2] | v[3])) | (v[2] & v[3]);
    endfunction

    // An empty group reports index 0 so an all-zero vector encodes to 0.
    function automatic logic [1:0] lowest4(input logic [3:0] v);
        return v[0] ? 2'd0 : v[1] ? 2'd1 : v[2] ? 2'd2 : v[3] ? 2'd3 : 2'd0;
    endfunction

endpackage

// File: rtl/pe_lowest_multi_detect.sv
// pe_lowest_multi_detect: combinational radix-4 recursive lowest-set-index encoder
// with any-hit, multi-hit (>= 2) and single-hit flags.
module pe_lowest_multi_detect
    import pe_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int BW    = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [BW-1:0]    idx,
    output logic             vld,
    output logic             multi,
    output logic             last
);
    localparam int PW  = pad_width(WIDTH);
    localparam int PBW = 2 * clog4(WIDTH);

    logic [PW-1:0]  v;
    logic [PBW-1:0] idx_p;
    logic [3:0]     q_vld;
    logic [1:0]     sel;

    // Padding bits are tied to zero, so the lowest hit always lies below WIDTH.
    assign v     = PW'(vec);
    assign sel   = lowest4(q_vld);
    assign vld   = |q_vld;
    assign idx   = idx_p[BW-1:0];

    if (PW == 4) begin : g_leaf
        assign q_vld = v;
        assign idx_p = sel;
        assign multi = two_plus(v);
        assign last  = vld && !multi;
    end else begin : g_node
        localparam int QW = PW / 4;
        logic [PBW-3:0] q_idx [4];
        logic [3:0]     q_multi;
        logic [3:0]     q_last;
        for (genvar i = 0; i < 4; i++) begin : g_q
            pe_lowest_multi_detect #(.WIDTH(QW), .BW(PBW - 2)) u_q (
                .vec   (v[i*QW +: QW]),
                .idx   (q_idx[i]),
                .vld   (q_vld[i]),
                .multi (q_multi[i]),
                .last  (q_last[i])
            );
        end
        assign idx_p = {sel, q_idx[sel]};
        assign multi = two_plus(q_vld) || (|q_multi);
        // Single hit overall: exactly one quarter is occupied and it holds one bit.
        assign last  = !two_plus(q_vld) && (|q_last);
    end

endmodule

// File: rtl/multi_hit_scan_encoder.sv
// multi_hit_scan_encoder: captures a hit vector and streams every set index,
// lowest first, one per out handshake, with hit count and multi/empty status.
module multi_hit_scan_encoder
    import pe_pkg::*;
#(
    parameter int WIDTH = 1024,
    parameter int BW    = $clog2(WIDTH),
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BW-1:0]    out_idx,
    output logic             out_last,
    output logic [CW-1:0]    hit_count,
    output logic             multi_hit,
    output logic             empty_pulse,
    output logic             busy
);
    state_t           state, state_nx;
    logic [WIDTH-1:0] vec, vec_nx;
    logic [CW-1:0]    in_cnt, count_nx;
    logic             multi_nx, empty_nx;
    logic             enc_vld, enc_multi, enc_last;

    pe_lowest_multi_detect #(.WIDTH(WIDTH), .BW(BW)) u_enc (
        .vec   (vec),
        .idx   (out_idx),
        .vld   (enc_vld),
        .multi (enc_multi),
        .last  (enc_last)
    );

    assign busy      = state == ST_SCAN;
    assign out_valid = busy && enc_vld;
    assign out_last  = out_valid && enc_last && !enc_multi;
    assign in_ready  = !busy && !flush;
    assign in_cnt    = CW'($countones(in_vec));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_IDLE;
            vec         <= '0;
            hit_count   <= '0;
            multi_hit   <= 1'b0;
            empty_pulse <= 1'b0;
        end else begin
            state       <= state_nx;
            vec         <= vec_nx;
            hit_count   <= count_nx;
            multi_hit   <= multi_nx;
            empty_pulse <= empty_nx;
        end
    end

    // Flush outranks a same-cycle out handshake; the presented index is dropped.
    always_comb begin
        state_nx = state;
        vec_nx   = vec;
        count_nx = hit_count;
        multi_nx = multi_hit;
        empty_nx = 1'b0;
        if (busy && flush) begin
            state_nx = ST_IDLE;
            vec_nx   = '0;
            count_nx = '0;
            multi_nx = 1'b0;
        end else if (in_valid && in_ready) begin
            vec_nx   = in_vec;
            count_nx = in_cnt;
            multi_nx = in_cnt > CW'(1);
            empty_nx = ~|in_vec;
            state_nx = (|in_vec) ? ST_SCAN : ST_IDLE;
        end else if (out_valid && out_ready) begin
            vec_nx[out_idx] = 1'b0;
            state_nx        = out_last ? ST_IDLE : ST_SCAN;
        end
    end

endmodule

// File: tb/tb_multi_hit_scan_encoder.sv
// tb_multi_hit_scan_encoder: scoreboard bench; expected index streams are queued
// at capture and a negedge monitor pops them on every out handshake.
`timescale 1ns/1ps
module tb_multi_hit_scan_encoder;
    localparam int W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b0, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic [W-1:0] in_vec = '0;
    logic         in_ready, out_valid, out_last, multi_hit, empty_pulse, busy;
    logic [3:0]   out_idx;
    logic [4:0]   hit_count;

    logic          p_in_valid = 1'b0, p_out_ready = 1'b0;
    logic [9:0]    p_vec = '0;
    logic [1023:0] b_vec = '0;
    logic          p_in_ready, p_out_valid, p_out_last, p_multi, p_empty, p_busy;
    logic [3:0]    p_idx, p_count;
    logic          b_in_ready, b_out_valid, b_out_last, b_multi, b_empty, b_busy;
    logic [9:0]    b_idx;
    logic [10:0]   b_count;

    multi_hit_scan_encoder #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
        .out_last(out_last), .hit_count(hit_count), .multi_hit(multi_hit),
        .empty_pulse(empty_pulse), .busy(busy)
    );

    multi_hit_scan_encoder #(.WIDTH(10)) dut_pad (
        .clk(clk), .rst(rst), .in_valid(p_in_valid), .in_ready(p_in_ready), .in_vec(p_vec),
        .flush(1'b0), .out_valid(p_out_valid), .out_ready(p_out_ready), .out_idx(p_idx),
        .out_last(p_out_last), .hit_count(p_count), .multi_hit(p_multi),
        .empty_pulse(p_empty), .busy(p_busy)
    );

    multi_hit_scan_encoder #(.WIDTH(1024)) dut_big (
        .clk(clk), .rst(rst), .in_valid(p_in_valid), .in_ready(b_in_ready), .in_vec(b_vec),
        .flush(1'b0), .out_valid(b_out_valid), .out_ready(p_out_ready), .out_idx(b_idx),
        .out_last(b_out_last), .hit_count(b_count), .multi_hit(b_multi),
        .empty_pulse(b_empty), .busy(b_busy)
    );

    typedef struct {
        int idx;
        bit last;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0, errors = 0, m_count = 0;
    bit   m_multi = 1'b0, exp_empty = 1'b0, rand_ready = 1'b0;

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            chk("out_valid", out_valid, exp_q.size() != 0);
            chk("busy", busy, exp_q.size() != 0);
            chk("in_ready", in_ready, exp_q.size() == 0 && !flush);
            chk("empty_pulse", empty_pulse, exp_empty);
            exp_empty = 1'b0;
            chk("hit_count", hit_count, m_count);
            chk("multi_hit", multi_hit, m_multi);
            if (out_valid && exp_q.size() != 0) begin
                chk("out_idx", out_idx, exp_q[0].idx);
                chk("out_last", out_last, exp_q[0].last);
                if (out_ready && !flush) void'(exp_q.pop_front());
            end else if (!out_valid) begin
                chk("out_last_idle", out_last, 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = $urandom_range(0, 3) != 0;
    endtask

    task automatic send(input logic [W-1:0] v);
        int n, k;
        in_valid = 1'b1;
        in_vec   = v;
        tick();
        in_valid = 1'b0;
        n = $countones(v);
        k = 0;
        m_count   = n;
        m_multi   = n >= 2;
        exp_empty = n == 0;
        for (int i = 0; i < W; i++) begin
            if (v[i]) begin
                k++;
                exp_q.push_back('{idx: i, last: (k == n)});
            end
        end
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 300 && exp_q.size() != 0; t++) tick();
        chk("scan_timeout", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic do_flush();
        bit act;
        act   = exp_q.size() != 0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        if (act) begin
            exp_q.delete();
            m_count = 0;
            m_multi = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        exp_q.delete();
        m_count   = 0;
        m_multi   = 1'b0;
        exp_empty = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] v;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_hit_count", hit_count, 0);
        chk("rst_multi_hit", multi_hit, 0);
        chk("rst_empty_pulse", empty_pulse, 0);
        chk("rst_busy", busy, 0);
        tick();

        out_ready = 1'b1;
        send(16'h8421);
        wait_idle();
        send(16'h0000);
        tick();
        tick();

        out_ready = 1'b0;
        send(16'h0100);
        repeat (5) tick();
        out_ready = 1'b1;
        wait_idle();

        send(16'hFFFF);
        for (int t = 0; t < 20 && exp_q.size() > 13; t++) tick();
        do_flush();
        @(negedge clk);
        chk("flush_out_valid", out_valid, 0);
        chk("flush_hit_count", hit_count, 0);
        chk("flush_busy", busy, 0);
        tick();
        send(16'h0002);
        wait_idle();

        send(16'hFFFF);
        tick();
        tick();
        do_reset();
        @(negedge clk);
        chk("rst_mid_out_valid", out_valid, 0);
        tick();

        rand_ready = 1'b1;
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 5))
                0:       v = '0;
                1:       v = W'(1) << $urandom_range(0, W - 1);
                2:       v = '1;
                default: v = W'($urandom);
            endcase
            send(v);
            for (int t = 0; t < 100 && exp_q.size() != 0; t++) begin
                case ($urandom_range(0, 39))
                    0:       do_flush();
                    1:       do_reset();
                    default: tick();
                endcase
            end
            chk("rand_scan_timeout", exp_q.size(), 0);
            exp_q.delete();
            if ($urandom_range(0, 7) == 0) do_flush();
        end
        rand_ready = 1'b0;
        out_ready  = 1'b0;
        tick();

        p_vec = 10'h200;
        b_vec = '0;
        b_vec[1023] = 1'b1;
        p_in_valid = 1'b1;
        tick();
        p_in_valid = 1'b0;
        @(negedge clk);
        chk("pad_single_valid", p_out_valid, 1);
        chk("pad_single_idx", p_idx, 9);
        chk("pad_single_last", p_out_last, 1);
        chk("pad_single_count", p_count, 1);
        chk("pad_single_multi", p_multi, 0);
        chk("big_single_valid", b_out_valid, 1);
        chk("big_single_idx", b_idx, 1023);
        chk("big_single_last", b_out_last, 1);
        chk("big_single_count", b_count, 1);
        p_out_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("pad_done_valid", p_out_valid, 0);
        chk("pad_done_ready", p_in_ready, 1);
        chk("big_done_valid", b_out_valid, 0);
        chk("big_done_ready", b_in_ready, 1);
        tick();

        p_vec = '1;
        b_vec = '1;
        p_in_valid = 1'b1;
        tick();
        p_in_valid = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            @(negedge clk);
            chk("big_full_idx", b_idx, i);
            chk("big_full_last", b_out_last, i == 1023);
            chk("big_full_count", b_count, 1024);
            if (i < 10) begin
                chk("pad_full_idx", p_idx, i);
                chk("pad_full_last", p_out_last, i == 9);
                chk("pad_full_count", p_count, 10);
            end else begin
                chk("pad_full_valid", p_out_valid, 0);
            end
            tick();
        end
        @(negedge clk);
        chk("big_full_done", b_out_valid, 0);
        chk("big_full_busy", b_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
